// File: rtl/seq_cla_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit carry-lookahead group per cycle,
// with a valid/ready handshake on both the operand and the result side.
module seq_cla_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NUM_CHUNKS = WIDTH / CHUNK;
    localparam int K_W        = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(NUM_CHUNKS - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [K_W-1:0]   k_q, k_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [31:0]      lo_idx;
    logic [CHUNK-1:0] grp_a, grp_b, grp_p, grp_g, grp_sum;
    logic [CHUNK:0]   grp_c;

    assign lo_idx = 32'(k_q) * 32'(CHUNK);

    // Each carry is a flat sum of products over g/p and the registered carry,
    // so no carry depends on the previous bit's carry.
    always_comb begin
        logic prod;
        logic acc;
        prod     = 1'b1;
        acc      = 1'b0;
        grp_a    = a_q[lo_idx +: CHUNK];
        grp_b    = b_q[lo_idx +: CHUNK];
        grp_p    = grp_a ^ grp_b;
        grp_g    = grp_a & grp_b;
        grp_c    = '0;
        grp_c[0] = carry_q;
        for (int i = 0; i < CHUNK; i++) begin
            prod = 1'b1;
            acc  = 1'b0;
            for (int j = i; j >= 0; j--) begin
                acc  = acc | (grp_g[j] & prod);
                prod = prod & grp_p[j];
            end
            grp_c[i+1] = acc | (prod & carry_q);
        end
        grp_sum = grp_p ^ grp_c[CHUNK-1:0];
    end

    // NOTE: every next-state signal gets its hold value first so no path
    // through the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        k_d     = k_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    // Subtraction is a + ~b + ~borrow, folded in at capture.
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = cin ^ sub;
                    k_d     = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sum_d[lo_idx +: CHUNK] = grp_sum;
                carry_d                = grp_c[CHUNK];
                if (k_q == K_LAST) begin
                    cout_d  = grp_c[CHUNK];
                    ovf_d   = grp_c[CHUNK] ^ grp_c[CHUNK-1];
                    state_d = ST_DONE;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            carry_q <= 1'b0;
            k_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            carry_q <= carry_d;
            k_q     <= k_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // NOTE: operand registers are deliberately not reset; they are always
    // loaded on acceptance before anything reads them.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: doc/seq_cla_adder.md
SEQ_CLA_ADDER -- requirements
Module: seq_cla_adder

Interface
REQ-001 Parameter WIDTH SHALL be defined with default 32; it is the operand and result width in bits.
REQ-002 Parameter CHUNK SHALL be defined with default 8; it is the lookahead group width processed per cycle, and WIDTH SHALL be an integer multiple of CHUNK.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit, SHALL be the reset: synchronous, active-high.
REQ-005 Port in_valid, input, 1 bit, SHALL indicate that the operands are presented.
REQ-006 Port in_ready, output, 1 bit, SHALL indicate that the block accepts operands.
REQ-007 Port a, input, WIDTH bits, SHALL be operand A.
REQ-008 Port b, input, WIDTH bits, SHALL be operand B.
REQ-009 Port cin, input, 1 bit, SHALL be carry-in when sub=0 and borrow-in when sub=1.
REQ-010 Port sub, input, 1 bit, SHALL select the operation: 0 = a+b+cin, 1 = a-b-cin.
REQ-011 Port out_valid, output, 1 bit, SHALL indicate that the result is valid.
REQ-012 Port out_ready, input, 1 bit, SHALL indicate that the consumer accepts the result.
REQ-013 Port sum, output, WIDTH bits, SHALL carry the result.
REQ-014 Port cout, output, 1 bit, SHALL carry the raw carry out of bit WIDTH-1; for sub=1, 0 means a borrow occurred.
REQ-015 Port ovf, output, 1 bit, SHALL flag two's-complement signed overflow.

Function
REQ-016 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-017 In IDLE, in_ready SHALL be 1; in RUN and DONE, in_ready SHALL be 0.
REQ-018 Acceptance SHALL occur on an edge with in_valid=1 in IDLE; at that edge the block captures a, b XOR {WIDTH{sub}}, and carry = cin XOR sub, clears chunk counter k to 0, and enters RUN.
REQ-019 In RUN, each cycle SHALL add chunk k (bits k*CHUNK+CHUNK-1 .. k*CHUNK) using CHUNK-bit carry-lookahead logic (per-bit p=a^b, g=a&b; carries from g/p terms and the registered carry, with no ripple chain).
REQ-020 Each RUN cycle SHALL write the chunk sum into sum, update the carry register with the group carry-out, and increment k.
REQ-021 On the RUN cycle with k = WIDTH/CHUNK-1, the block SHALL set cout to the group carry-out, set ovf = (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1), and enter DONE.
REQ-022 Latency: with acceptance at edge T, out_valid SHALL be 1 from edge T+WIDTH/CHUNK.
REQ-023 In DONE, out_valid SHALL be 1, and sum, cout and ovf SHALL be held stable until out_ready=1.
REQ-024 On an edge with out_ready=1 in DONE, the block SHALL return to IDLE and out_valid SHALL fall.
REQ-025 in_valid in RUN or DONE SHALL be ignored, and operand changes after acceptance SHALL have no effect on the result.
REQ-026 out_ready outside DONE SHALL be ignored.
REQ-027 Throughput SHALL be one operation per WIDTH/CHUNK+2 cycles minimum; back-to-back acceptance from DONE is not supported.
REQ-028 With CHUNK=WIDTH, RUN SHALL last exactly one cycle.
REQ-029 sum SHALL be undefined-but-stable mid-RUN (partially updated); the consumer uses sum only when out_valid=1.

Reset
REQ-030 On an edge with rst=1, the block SHALL enter IDLE and clear sum, cout, ovf, out_valid, k and carry to 0, with in_ready=1 from the following cycle.
REQ-031 rst SHALL take priority over all handshakes; a reset in RUN or DONE SHALL abort the operation and never produce out_valid for it.

Verification (WIDTH=32, CHUNK=8 unless stated)
REQ-032 a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 -> sum=0x00000000, cout=1, ovf=0, out_valid 4 cycles after acceptance.
REQ-033 a=0x7FFFFFFF, b=0x00000001, cin=0, sub=0 -> sum=0x80000000, cout=0, ovf=1.
REQ-034 a=0x00000005, b=0x00000007, cin=0, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0; also a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, cout=1, ovf=1.
REQ-035 out_ready held 0 for 3 cycles in DONE, with in_valid=1 throughout -> sum/cout/ovf/out_valid stable, in_ready=0, no new acceptance; out_ready=1 -> IDLE next cycle.
REQ-036 rst=1 after two RUN cycles -> next cycle all outputs 0, in_ready=1, no out_valid pulse; a subsequent op computes correctly.
REQ-037 Parameter sweep CHUNK=8 with WIDTH=8, and CHUNK=4 with WIDTH=16 -> latency 1 and 4 respectively, and 1000 random ops per configuration match a reference model on sum, cout and ovf.
